cpu_intc: RTL
=============

# cpu_intc

Machine-level external interrupt controller sitting directly upstream of the CPU CSR block. It collects up to `NUM_SOURCES` device interrupt lines and gates each through a per-source gateway. It drives the single `irq_o` line into the CSR block's `interrupt_i`. Software enables, claims and completes interrupts through a memory-mapped register port whose read latency and zero-when-idle behaviour match the CSR read port.

## Interface
- `NUM_SOURCES`, default 8: number of interrupt sources, 1..31. Source IDs are 1..`NUM_SOURCES`; ID 0 means "none".
- `EDGE_MASK`, default `'0`: bit n=1 makes source n+1 rising-edge triggered; bit n=0 makes it level-high.
- `clk_i` in 1: clock.
- `reset_ni` in 1: reset. One clock; reset is synchronous and active-low.
- `src_i` in `NUM_SOURCES`: raw interrupt lines, synchronous to `clk_i`. Bit n is source ID n+1.
- `addr_i` in 2: register select, word offset already decoded by the bus.
- `read_enable_i` in 1: read strobe.
- `read_data_o` out 32: registered read data.
- `write_enable_i` in 1: write strobe.
- `write_data_i` in 32: write data.
- `irq_o` out 1: external interrupt request, registered.

## Operation
- Registers, by `addr_i`:
  - 0 ENABLE: RW. Bits [`NUM_SOURCES`-1:0] are used; upper bits read 0.
  - 1 PENDING: RO. Bit n reads 1 when source n+1 is in PENDING. Writes are ignored.
  - 2 CLAIM/COMPLETE: a read claims, a write completes.
  - 3: reserved. Reads return 0; writes are ignored.
- Each gateway has three states: IDLE, PENDING and IN_SERVICE, plus a `repend` flag.
  - IDLE -> PENDING: on trigger. Level trigger is `src` high. Edge trigger is `src` high with the previous sample low.
  - PENDING -> IN_SERVICE: when claimed.
  - IN_SERVICE -> IDLE: on a COMPLETE write with this ID, if `repend`=0.
  - IN_SERVICE -> PENDING: on COMPLETE, if `repend`=1 (edge sources), or if the line is still high that cycle (level sources). `repend` is cleared on COMPLETE.
  - Edge trigger while in PENDING: absorbed, no counting.
  - Edge trigger while in IN_SERVICE: sets `repend`.
  - Level line while in IN_SERVICE: ignored.
- Claim read:
  - Returns the lowest ID that is PENDING and enabled. That source moves to IN_SERVICE.
  - If no source is PENDING and enabled, returns 0 and changes no state.
- COMPLETE write:
  - `write_data_i[4:0]` is the ID.
  - Ignored if the ID is 0, greater than `NUM_SOURCES`, or not IN_SERVICE.
- Disabled sources still become PENDING. They do not drive `irq_o` and cannot be claimed.
- `irq_o` is the OR over sources of (PENDING AND enabled).

## Timing
- Reset values:
  - All gateways IDLE with `repend`=0.
  - ENABLE=0, `irq_o`=0, `read_data_o`=0.
  - Previous-sample flops are 0, so a source that is high on the first cycle after reset counts as a rising edge.
- Reset mid-operation discards all PENDING and IN_SERVICE state on the next edge.
- `src_i` to state: a trigger sampled at edge k gives PENDING after edge k.
- State to `irq_o`: `irq_o` reflects state one cycle later, so trigger-to-`irq_o` is 2 cycles.
- Reads: `read_data_o` is valid the cycle after the `read_enable_i` edge and is 0 in any cycle following no read. Claim side effects commit on the same edge as the read.
- `irq_o` deasserts the cycle after the claim edge if no other enabled source is pending.
- Simultaneous events on one edge:
  - Claim of ID x and trigger of ID x: claim wins. x goes to IN_SERVICE; for edge sources the trigger sets `repend`.
  - COMPLETE of x and edge trigger of x: x goes to PENDING.
  - Write to ENABLE and claim read: the claim uses the old ENABLE value.
  - Read and write to CLAIM/COMPLETE in the same cycle: the complete is applied first. The claim sees post-complete state only on the next access, so this cycle's claim uses pre-edge state.

## Structure
- In package `common`:
  - `intc_reg_t` enum: `INTC_ENABLE`=0, `INTC_PENDING`=1, `INTC_CLAIM`=2.
  - `intc_state_t` enum: IDLE, PENDING, IN_SERVICE.
  - `INTC_ID_NONE`=0.
- Sub-module `cpu_intc_gateway`, one instance per source via generate. It holds the state, `repend` and previous-sample flop. Its inputs are `src`, `edge_mode`, `claim` and `complete`; its output is `pending`.
- The top level holds ENABLE, the lowest-ID priority encoder, the read mux and the `irq_o` flop.
- Estimated size is about 200 lines.

## Test plan
- Reset with all inputs 0, then ENABLE=0x01 and level source 1 held high: `irq_o`=1 two cycles after the rise. Claim read returns 1; `irq_o`=0 next cycle. COMPLETE(1) with the line still high: PENDING bit0=1 again.
- ENABLE=0x06 with sources 2 and 3 pending together: first claim returns 2, second returns 3, third returns 0. PENDING reads 0.
- Edge source 4 (`EDGE_MASK`=0x08), ENABLE=0x08: claim returns 4. Pulse `src_i[3]` while IN_SERVICE, then COMPLETE(4): PENDING bit3=1 and `irq_o` reasserts.
- COMPLETE(5) while 5 is IDLE, and COMPLETE(0): no state change, `irq_o` unchanged.
- Source 1 pending with ENABLE=0: `irq_o`=0 and claim returns 0. Write ENABLE=1: `irq_o`=1 two cycles later.
- Deassert `reset_ni` with source 2 IN_SERVICE: after the edge, PENDING=0, ENABLE=0, `irq_o`=0, and claim returns 0.

Source files
------------

// File: rtl/common.sv
// Shared types and constants for the machine-level external interrupt controller.
package common;

    typedef enum logic [1:0] {
        INTC_ENABLE  = 2'd0,
        INTC_PENDING = 2'd1,
        INTC_CLAIM   = 2'd2
    } intc_reg_t;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PENDING    = 2'd1,
        IN_SERVICE = 2'd2
    } intc_state_t;

    localparam logic [4:0] INTC_ID_NONE = 5'd0;

endpackage

// File: rtl/cpu_intc_gateway.sv
// Per-source interrupt gateway: turns a raw level or edge line into a
// PENDING / IN_SERVICE lifecycle driven by claim and complete pulses.
//
// state      | meaning
// IDLE       | no request outstanding
// PENDING    | request waiting to be claimed
// IN_SERVICE | claimed by software, waiting for COMPLETE
module cpu_intc_gateway
    import common::*;
(
    input  logic clk_i,
    input  logic reset_ni,
    input  logic src_i,
    input  logic edge_mode_i,
    input  logic claim_i,
    input  logic complete_i,
    output logic pending_o
);

    intc_state_t state_q;
    logic        repend_q;
    logic        prev_q;
    logic        trig;

    assign trig      = edge_mode_i ? (src_i & ~prev_q) : src_i;
    assign pending_o = (state_q == PENDING);

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q  <= IDLE;
            repend_q <= 1'b0;
            prev_q   <= 1'b0;
        end else begin
            prev_q <= src_i;
            case (state_q)
                IDLE: begin
                    if (trig) state_q <= PENDING;
                end
                PENDING: begin
                    // A trigger coinciding with the claim must not be lost for edge sources.
                    if (claim_i) begin
                        state_q  <= IN_SERVICE;
                        repend_q <= edge_mode_i & trig;
                    end
                end
                IN_SERVICE: begin
                    if (complete_i) begin
                        state_q  <= (edge_mode_i ? (repend_q | trig) : src_i) ? PENDING : IDLE;
                        repend_q <= 1'b0;
                    end else if (edge_mode_i && trig) begin
                        repend_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/cpu_intc.sv
// External interrupt controller: per-source gateways, enable register,
// lowest-ID claim arbitration and a registered bus read port.
module cpu_intc
    import common::*;
#(
    parameter int                     NUM_SOURCES = 8,
    parameter logic [NUM_SOURCES-1:0] EDGE_MASK   = '0
) (
    input  logic                   clk_i,
    input  logic                   reset_ni,
    input  logic [NUM_SOURCES-1:0] src_i,
    input  logic [1:0]             addr_i,
    input  logic                   read_enable_i,
    output logic [31:0]            read_data_o,
    input  logic                   write_enable_i,
    input  logic [31:0]            write_data_i,
    output logic                   irq_o
);

    logic [NUM_SOURCES-1:0] enable_q;
    logic [NUM_SOURCES-1:0] pending;
    logic [NUM_SOURCES-1:0] claim_vec;
    logic [NUM_SOURCES-1:0] complete_vec;
    logic [4:0]             claim_id;
    logic                   found;
    logic                   claim_rd;
    logic                   complete_wr;
    logic [31:0]            read_data_d;
    logic [31:0]            read_data_q;
    logic                   irq_q;
    logic                   unused_wdata;

    assign claim_rd     = read_enable_i && (addr_i == INTC_CLAIM);
    assign complete_wr  = write_enable_i && (addr_i == INTC_CLAIM);
    assign unused_wdata = ^write_data_i;

    for (genvar g = 0; g < NUM_SOURCES; g++) begin : g_gw
        cpu_intc_gateway u_gw (
            .clk_i       (clk_i),
            .reset_ni    (reset_ni),
            .src_i       (src_i[g]),
            .edge_mode_i (EDGE_MASK[g]),
            .claim_i     (claim_vec[g]),
            .complete_i  (complete_vec[g]),
            .pending_o   (pending[g])
        );
    end

    // Lowest enabled pending ID wins; old ENABLE value is used on the write edge.
    always_comb begin
        claim_id  = INTC_ID_NONE;
        claim_vec = '0;
        found     = 1'b0;
        for (int i = 0; i < NUM_SOURCES; i++) begin
            if (!found && pending[i] && enable_q[i]) begin
                found        = 1'b1;
                claim_id     = 5'(i + 1);
                claim_vec[i] = claim_rd;
            end
        end
    end

    // ID 0 and out-of-range IDs match no gateway; non-IN_SERVICE gateways ignore it.
    always_comb begin
        complete_vec = '0;
        for (int i = 0; i < NUM_SOURCES; i++) begin
            complete_vec[i] = complete_wr && (write_data_i[4:0] == 5'(i + 1));
        end
    end

    always_comb begin
        read_data_d = '0;
        case (addr_i)
            INTC_ENABLE:  read_data_d = 32'(enable_q);
            INTC_PENDING: read_data_d = 32'(pending);
            INTC_CLAIM:   read_data_d = 32'(claim_id);
            default:      read_data_d = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            enable_q    <= '0;
            read_data_q <= '0;
            irq_q       <= 1'b0;
        end else begin
            if (write_enable_i && (addr_i == INTC_ENABLE)) begin
                enable_q <= write_data_i[NUM_SOURCES-1:0];
            end
            read_data_q <= read_enable_i ? read_data_d : '0;
            irq_q       <= |(pending & enable_q);
        end
    end

    assign read_data_o = read_data_q;
    assign irq_o       = irq_q;

endmodule
